cpu_cfg: RTL and testbench
==========================

# cpu_cfg

CPU-side endpoint of the N64 configuration mailbox. It receives command requests that the N64 posts through the config interface, presents the command and data words to the on-board soft CPU as memory-mapped registers, and drives status (ready/busy/error) plus data write-back toward the N64-visible config registers. It also raises an interrupt per command and aborts stalled commands with a watchdog.

## Interface
Parameters:
- TIMEOUT_CYCLES, 24'd8_000_000: busy cycles before a command is auto-completed with error; 0 disables the watchdog.
- TIMEOUT_W, 24: width of the watchdog counter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU bus access strobe, one cycle per access.
- cpu_write  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_address  in  3  word index, register select.
- cpu_wdata  in  32  CPU write data.
- cpu_ack  out  1  access complete, one cycle.
- cpu_rdata  out  32  read data, valid with cpu_ack, 0 otherwise.
- cfg_cmd_request  in  1  one-cycle pulse: new command posted by N64.
- cfg_cmd  in  8  command byte; valid with cfg_cmd_request.
- cfg_data0  in  32  current data word 0.
- cfg_data1  in  32  current data word 1.
- cfg_cpu_ready  out  1  CPU firmware running.
- cfg_cpu_busy  out  1  command in progress.
- cfg_cmd_error  out  1  last command failed.
- cfg_data_write  out  2  one-hot write strobe for data word 0/1.
- cfg_wdata  out  32  data for cfg_data_write.
- irq  out  1  level interrupt to CPU.

## Operation
Registers (cpu_address):
- 0 SR: bit0 ready (RW, write 1 sets, write 0 clears), bit1 busy (RO), bit2 error (RO), bit3 irq_pending (RO), bit4 irq_enable (RW), bit5 overrun (RO), bit6 timeout (RO); other bits read 0, write ignored.
- 1 CMD: RO, {24'd0, latched command}.
- 2 DATA0: read returns cfg_data0; write pulses cfg_data_write = 2'b01, cfg_wdata = cpu_wdata.
- 3 DATA1: as DATA0 with 2'b10.
- 4 DONE: WO; write completes the current command: busy←0, error←cpu_wdata[0], irq_pending←0, overrun←0, timeout←0. Ignored if not busy, except that irq_pending, overrun and timeout still clear.
- 5-7: read 0, write ignored.

Command flow, two states IDLE/BUSY, mirrored by busy:
- IDLE + cfg_cmd_request: latch cfg_cmd, busy←1, error←0, timeout←0, irq_pending←1, watchdog←0 -> BUSY.
- BUSY + cfg_cmd_request: command dropped, latched cmd unchanged, overrun←1.
- BUSY + DONE write -> IDLE.
- BUSY, watchdog == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): busy←0, error←1, timeout←1, irq_pending←1 -> IDLE.
- DONE write and cfg_cmd_request in the same cycle: the new command wins. Final state is BUSY with the new cmd latched, error 0, irq_pending 1, overrun 0.
- Watchdog expiry and cfg_cmd_request in the same cycle: expiry applies, then the command is accepted. Final state is busy 1, error 0, timeout 1, new cmd latched.
- DONE write and watchdog expiry in the same cycle: the DONE write wins and the timeout flag is not set.
- Watchdog counter increments by 1 each BUSY cycle and saturates; it never wraps.
- irq = irq_pending & irq_enable.

## Timing
- Every cpu_req is acknowledged exactly 1 cycle later. Back-to-back requests are allowed, one per cycle.
- cpu_rdata is registered and samples register state at the request cycle.
- cfg_data_write and cfg_wdata are registered, 1 cycle after the write request, asserted for 1 cycle.
- Status outputs update 1 cycle after the causing event.
- A read of SR in the cycle cfg_cmd_request arrives returns the pre-request value.
- irq is registered and follows irq_pending/irq_enable with 1 cycle of latency.
- Reset (reset_n=0 at a clock edge, including mid-command) forces all of the following to 0:
  - outputs: cpu_ack, cpu_rdata, cfg_data_write, cfg_wdata, cfg_cpu_ready, cfg_cpu_busy, cfg_cmd_error, irq;
  - internal state: latched cmd, irq_enable, irq_pending, overrun, timeout, watchdog.
- A cfg_cmd_request coinciding with reset is lost.

## Test plan
- Reset, then read SR -> rdata 0x0. Write SR 0x11 -> cfg_cpu_ready=1 and irq_enable=1; readback 0x11.
- Command flow:
  - With irq_enable set, pulse cfg_cmd_request with cfg_cmd=0x53 -> busy=1 and irq=1 two cycles later; CMD reads 0x53.
  - Write DONE 0x1 -> busy=0, error=1, irq=0.
- Write DATA1 0xDEADBEEF -> one cycle later cfg_data_write=2'b10 and cfg_wdata=0xDEADBEEF for exactly one cycle. With cfg_data0=0x12345678, read DATA0 -> rdata 0x12345678.
- While busy with cmd 0x53, pulse a request with cfg_cmd=0x44 -> CMD still 0x53 and SR bit5=1. In the same cycle as the DONE write, pulse a request with 0x44 -> busy=1, CMD=0x44, overrun=0.
- With TIMEOUT_CYCLES=16, post a command and never write DONE -> on the 17th cycle after the request, busy=0, error=1, timeout=1, irq_pending=1.
- Assert reset_n=0 for one cycle while busy with irq high -> all outputs 0 on the next cycle, and CMD reads 0.

Source files
------------

// File: rtl/cpu_cfg.sv
// CPU-side endpoint of the N64 configuration mailbox: command/status registers,
// data write-back strobes, per-command interrupt and a busy watchdog.
module cpu_cfg #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000,
  parameter int unsigned TIMEOUT_W      = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [2:0]  cpu_address,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        cfg_cmd_request,
  input  logic [7:0]  cfg_cmd,
  input  logic [31:0] cfg_data0,
  input  logic [31:0] cfg_data1,
  output logic        cfg_cpu_ready,
  output logic        cfg_cpu_busy,
  output logic        cfg_cmd_error,
  output logic [1:0]  cfg_data_write,
  output logic [31:0] cfg_wdata,
  output logic        irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 24'd1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = TIMEOUT_W'(1'b1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = {TIMEOUT_W{1'b1}};
  localparam logic WD_EN = (TIMEOUT_CYCLES != 24'd0);

  logic [0:0]           state_r, state_s;
  logic [7:0]           cmd_r, cmd_s;
  logic                 error_r, error_s;
  logic                 pend_r, pend_s;
  logic                 over_r, over_s;
  logic                 tmo_r, tmo_s;
  logic                 ready_r, ready_s;
  logic                 ien_r, ien_s;
  logic [TIMEOUT_W-1:0] wd_r, wd_s;

  logic        wr_s, done_s, sr_wr_s, busy_s, expire_s;
  logic [31:0] sr_s, rd_s;

  assign wr_s     = cpu_req & cpu_write;
  assign done_s   = wr_s & (cpu_address == 3'd4);
  assign sr_wr_s  = wr_s & (cpu_address == 3'd0);
  assign busy_s   = (state_r == ST_BUSY);
  // A DONE write in the expiry cycle takes precedence, so expiry is masked by it.
  assign expire_s = busy_s & WD_EN & (wd_r == WD_LAST) & ~done_s;
  assign sr_s     = {25'd0, tmo_r, over_r, ien_r, pend_r, error_r, busy_s, ready_r};

  // Next-state: completion/expiry first, then a request may be accepted into the freed slot.
  always_comb begin
    state_s = state_r;
    cmd_s   = cmd_r;
    error_s = error_r;
    pend_s  = pend_r;
    over_s  = over_r;
    tmo_s   = tmo_r;
    wd_s    = wd_r;
    ready_s = sr_wr_s ? cpu_wdata[0] : ready_r;
    ien_s   = sr_wr_s ? cpu_wdata[4] : ien_r;
    if (busy_s) begin
      wd_s = (wd_r == WD_MAX) ? wd_r : wd_r + WD_ONE;
    end else begin
      wd_s = wd_r;
    end
    if (done_s) begin
      pend_s = 1'b0;
      over_s = 1'b0;
      tmo_s  = 1'b0;
      if (busy_s) begin
        state_s = ST_IDLE;
        error_s = cpu_wdata[0];
      end else begin
        state_s = state_r;
      end
    end else if (expire_s) begin
      state_s = ST_IDLE;
      error_s = 1'b1;
      tmo_s   = 1'b1;
      pend_s  = 1'b1;
    end else begin
      state_s = state_r;
    end
    if (cfg_cmd_request) begin
      if (state_s == ST_IDLE) begin
        state_s = ST_BUSY;
        cmd_s   = cfg_cmd;
        error_s = 1'b0;
        pend_s  = 1'b1;
        tmo_s   = expire_s;
        wd_s    = {TIMEOUT_W{1'b0}};
      end else begin
        over_s = 1'b1;
      end
    end else begin
      cmd_s = cmd_s;
    end
  end

  // Register read multiplexer, sampled in the request cycle.
  always_comb begin
    case (cpu_address)
      3'd0:    rd_s = sr_s;
      3'd1:    rd_s = {24'd0, cmd_r};
      3'd2:    rd_s = cfg_data0;
      3'd3:    rd_s = cfg_data1;
      default: rd_s = 32'd0;
    endcase
  end

  // Mailbox state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cmd_r   <= 8'd0;
      error_r <= 1'b0;
      pend_r  <= 1'b0;
      over_r  <= 1'b0;
      tmo_r   <= 1'b0;
      ready_r <= 1'b0;
      ien_r   <= 1'b0;
      wd_r    <= {TIMEOUT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cmd_r   <= cmd_s;
      error_r <= error_s;
      pend_r  <= pend_s;
      over_r  <= over_s;
      tmo_r   <= tmo_s;
      ready_r <= ready_s;
      ien_r   <= ien_s;
      wd_r    <= wd_s;
    end
  end

  // Bus response, data write-back strobes and interrupt, all one cycle after the cause.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_ack        <= 1'b0;
      cpu_rdata      <= 32'd0;
      cfg_data_write <= 2'b00;
      cfg_wdata      <= 32'd0;
      irq            <= 1'b0;
    end else begin
      cpu_ack   <= cpu_req;
      cpu_rdata <= (cpu_req && !cpu_write) ? rd_s : 32'd0;
      irq       <= pend_r & ien_r;
      if (wr_s && (cpu_address == 3'd2)) begin
        cfg_data_write <= 2'b01;
        cfg_wdata      <= cpu_wdata;
      end else if (wr_s && (cpu_address == 3'd3)) begin
        cfg_data_write <= 2'b10;
        cfg_wdata      <= cpu_wdata;
      end else begin
        cfg_data_write <= 2'b00;
        cfg_wdata      <= 32'd0;
      end
    end
  end

  assign cfg_cpu_ready = ready_r;
  assign cfg_cpu_busy  = state_r[0];
  assign cfg_cmd_error = error_r;

endmodule

// File: tb/tb_cpu_cfg.sv
// Self-checking bench for cpu_cfg: directed corner sequences, a register-access
// vector table, and randomized traffic against a behavioural mailbox model.
module tb_cpu_cfg;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n, cpu_req, cpu_write, cfg_cmd_request;
  logic [2:0]  cpu_address;
  logic [31:0] cpu_wdata, cfg_data0, cfg_data1;
  logic [7:0]  cfg_cmd;
  logic        cpu_ack, cfg_cpu_ready, cfg_cpu_busy, cfg_cmd_error, irq;
  logic [31:0] cpu_rdata, cfg_wdata;
  logic [1:0]  cfg_data_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_cfg #(.TIMEOUT_CYCLES(24'd16), .TIMEOUT_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cfg_cmd_request(cfg_cmd_request), .cfg_cmd(cfg_cmd),
    .cfg_data0(cfg_data0), .cfg_data1(cfg_data1), .cfg_cpu_ready(cfg_cpu_ready),
    .cfg_cpu_busy(cfg_cpu_busy), .cfg_cmd_error(cfg_cmd_error),
    .cfg_data_write(cfg_data_write), .cfg_wdata(cfg_wdata), .irq(irq)
  );

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_dw;
    logic [31:0] exp_wdata;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic acc(input logic [2:0] a, input logic w, input logic [31:0] d);
    cpu_req = 1'b1; cpu_write = w; cpu_address = a; cpu_wdata = d;
    tick();
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_address = 3'd0; cpu_wdata = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    acc(a, 1'b0, 32'd0);
    chk(name, cpu_rdata, exp);
  endtask

  task automatic post(input logic [7:0] c);
    cfg_cmd_request = 1'b1; cfg_cmd = c;
    tick();
    cfg_cmd_request = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
  endtask

  // Behavioural model of the mailbox, state as seen by software.
  logic       m_busy, m_err, m_pend, m_ovr, m_tmo, m_rdy, m_ien;
  logic [7:0] m_cmd;
  int         m_age;

  initial begin
    logic [31:0] sr, e_rd, e_wd;
    logic [1:0]  e_dw;
    logic        e_irq, done, expire, was_busy;

    reset_n = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_address = 3'd0;
    cpu_wdata = 32'd0; cfg_cmd_request = 1'b0; cfg_cmd = 8'd0;
    cfg_data0 = 32'd0; cfg_data1 = 32'd0;

    // Reset state and SR write
    do_reset();
    chk("rst_outputs", {cpu_ack, cfg_cpu_ready, cfg_cpu_busy, cfg_cmd_error, irq, cfg_data_write}, 32'd0);
    rd(3'd0, 32'h0, "rst_sr");
    acc(3'd0, 1'b1, 32'h11);
    chk("ready_set", cfg_cpu_ready, 32'd1);
    rd(3'd0, 32'h11, "sr_readback");

    // Command flow
    post(8'h53);
    tick();
    chk("cmd_busy", cfg_cpu_busy, 32'd1);
    chk("cmd_irq", irq, 32'd1);
    rd(3'd1, 32'h53, "cmd_read");
    rd(3'd0, 32'h1B, "sr_busy");
    acc(3'd4, 1'b1, 32'h1);
    chk("done_busy", cfg_cpu_busy, 32'd0);
    chk("done_error", cfg_cmd_error, 32'd1);
    tick();
    chk("done_irq", irq, 32'd0);

    // Data write-back and readback
    acc(3'd3, 1'b1, 32'hDEADBEEF);
    chk("dw1_strobe", cfg_data_write, 32'd2);
    chk("dw1_wdata", cfg_wdata, 32'hDEADBEEF);
    tick();
    chk("dw1_once", cfg_data_write, 32'd0);
    cfg_data0 = 32'h12345678;
    rd(3'd2, 32'h12345678, "data0_read");

    // Overrun, then DONE together with a new request
    post(8'h53);
    post(8'h44);
    rd(3'd1, 32'h53, "ovr_cmd_kept");
    acc(3'd0, 1'b0, 32'd0);
    chk("ovr_flag", (cpu_rdata >> 5) & 32'd1, 32'd1);
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 3'd4; cpu_wdata = 32'd0;
    cfg_cmd_request = 1'b1; cfg_cmd = 8'h44;
    tick();
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_address = 3'd0; cfg_cmd_request = 1'b0;
    chk("done_req_busy", cfg_cpu_busy, 32'd1);
    rd(3'd1, 32'h44, "done_req_cmd");
    acc(3'd0, 1'b0, 32'd0);
    chk("done_req_ovr", (cpu_rdata >> 5) & 32'd1, 32'd0);
    chk("done_req_err", cfg_cmd_error, 32'd0);
    acc(3'd4, 1'b1, 32'h0);

    // Watchdog expiry on the 17th cycle after the request
    post(8'h22);
    ticks(TMO - 1);
    chk("wd_still_busy", cfg_cpu_busy, 32'd1);
    tick();
    chk("wd_busy", cfg_cpu_busy, 32'd0);
    chk("wd_error", cfg_cmd_error, 32'd1);
    rd(3'd0, 32'h5D, "wd_sr");

    // Expiry and a new request in the same cycle
    post(8'h33);
    ticks(TMO - 1);
    post(8'h66);
    rd(3'd0, 32'h5B, "exp_req_sr");
    rd(3'd1, 32'h66, "exp_req_cmd");

    // DONE write and expiry in the same cycle
    ticks(TMO - 1 - 2);
    acc(3'd4, 1'b1, 32'h0);
    chk("done_exp_err", cfg_cmd_error, 32'd0);
    rd(3'd0, 32'h11, "done_exp_sr");

    // Reset mid-command with irq high; coincident request is lost
    post(8'h77);
    tick();
    chk("pre_rst_irq", irq, 32'd1);
    reset_n = 1'b0; cfg_cmd_request = 1'b1; cfg_cmd = 8'h99;
    tick();
    reset_n = 1'b1; cfg_cmd_request = 1'b0;
    chk("rst_mid_outputs", {cpu_ack, cfg_cpu_ready, cfg_cpu_busy, cfg_cmd_error, irq, cfg_data_write}, 32'd0);
    chk("rst_mid_rdata", cpu_rdata | cfg_wdata, 32'd0);
    rd(3'd1, 32'h0, "rst_mid_cmd");
    rd(3'd0, 32'h0, "rst_mid_sr");

    // Register access vector table
    cfg_data0 = 32'h0BADC0DE; cfg_data1 = 32'hCAFEF00D;
    vecs[0]  = '{3'd0, 1'b1, 32'h11,       32'h0,        2'b00, 32'h0,        1'b1};
    vecs[1]  = '{3'd0, 1'b0, 32'h0,        32'h11,       2'b00, 32'h0,        1'b1};
    vecs[2]  = '{3'd0, 1'b1, 32'hFFFFFFFE, 32'h0,        2'b00, 32'h0,        1'b0};
    vecs[3]  = '{3'd0, 1'b0, 32'h0,        32'h10,       2'b00, 32'h0,        1'b0};
    vecs[4]  = '{3'd6, 1'b1, 32'hFFFFFFFF, 32'h0,        2'b00, 32'h0,        1'b0};
    vecs[5]  = '{3'd5, 1'b0, 32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[6]  = '{3'd7, 1'b0, 32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[7]  = '{3'd2, 1'b1, 32'hA5A55A5A, 32'h0,        2'b01, 32'hA5A55A5A, 1'b0};
    vecs[8]  = '{3'd3, 1'b0, 32'h0,        32'hCAFEF00D, 2'b00, 32'h0,        1'b0};
    vecs[9]  = '{3'd1, 1'b0, 32'h0,        32'h0,        2'b00, 32'h0,        1'b0};
    vecs[10] = '{3'd0, 1'b1, 32'h01,       32'h0,        2'b00, 32'h0,        1'b1};
    vecs[11] = '{3'd0, 1'b0, 32'h0,        32'h01,       2'b00, 32'h0,        1'b1};
    vecs[12] = '{3'd4, 1'b1, 32'h1,        32'h0,        2'b00, 32'h0,        1'b1};
    vecs[13] = '{3'd0, 1'b0, 32'h0,        32'h01,       2'b00, 32'h0,        1'b1};
    vecs[14] = '{3'd2, 1'b0, 32'h0,        32'h0BADC0DE, 2'b00, 32'h0,        1'b1};
    for (int i = 0; i < 15; i++) begin
      acc(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
      chk($sformatf("vec%0d_ack", i), cpu_ack, 32'd1);
      chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_dw", i), cfg_data_write, {30'd0, vecs[i].exp_dw});
      chk($sformatf("vec%0d_wdata", i), cfg_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_ready", i), cfg_cpu_ready, {31'd0, vecs[i].exp_ready});
    end

    // Randomized traffic against the model
    do_reset();
    m_busy = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
    m_rdy = 1'b0; m_ien = 1'b0; m_cmd = 8'd0; m_age = 0;
    for (int n = 0; n < 3000; n++) begin
      cpu_req         = ($urandom_range(2) == 0);
      cpu_write       = $urandom_range(1);
      cpu_address     = 3'($urandom_range(7));
      cpu_wdata       = $urandom;
      cfg_cmd_request = ($urandom_range(11) == 0);
      cfg_cmd         = 8'($urandom);
      cfg_data0       = $urandom;
      cfg_data1       = $urandom;

      sr = {25'd0, m_tmo, m_ovr, m_ien, m_pend, m_err, m_busy, m_rdy};
      e_rd = 32'd0;
      if (cpu_req && !cpu_write) begin
        case (cpu_address)
          3'd0: e_rd = sr;
          3'd1: e_rd = {24'd0, m_cmd};
          3'd2: e_rd = cfg_data0;
          3'd3: e_rd = cfg_data1;
          default: e_rd = 32'd0;
        endcase
      end
      e_dw = 2'b00; e_wd = 32'd0;
      if (cpu_req && cpu_write && cpu_address == 3'd2) begin e_dw = 2'b01; e_wd = cpu_wdata; end
      if (cpu_req && cpu_write && cpu_address == 3'd3) begin e_dw = 2'b10; e_wd = cpu_wdata; end
      e_irq = m_pend & m_ien;

      if (cpu_req && cpu_write && cpu_address == 3'd0) begin
        m_rdy = cpu_wdata[0];
        m_ien = cpu_wdata[4];
      end
      done     = cpu_req && cpu_write && cpu_address == 3'd4;
      was_busy = m_busy;
      expire   = m_busy && (m_age == TMO - 1) && !done;
      if (done) begin
        m_pend = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
        if (m_busy) begin m_busy = 1'b0; m_err = cpu_wdata[0]; end
      end else if (expire) begin
        m_busy = 1'b0; m_err = 1'b1; m_tmo = 1'b1; m_pend = 1'b1;
      end
      if (was_busy) m_age++;
      if (cfg_cmd_request) begin
        if (!m_busy) begin
          m_busy = 1'b1; m_cmd = cfg_cmd; m_err = 1'b0; m_pend = 1'b1; m_age = 0;
          if (!expire) m_tmo = 1'b0;
        end else begin
          m_ovr = 1'b1;
        end
      end

      tick();
      chk("rnd_ack", cpu_ack, {31'd0, cpu_req});
      chk("rnd_rdata", cpu_rdata, e_rd);
      chk("rnd_dw", cfg_data_write, {30'd0, e_dw});
      chk("rnd_wdata", cfg_wdata, e_wd);
      chk("rnd_status", {cfg_cpu_ready, cfg_cpu_busy, cfg_cmd_error, irq},
          {28'd0, m_rdy, m_busy, m_err, e_irq});
    end
    cpu_req = 1'b0; cfg_cmd_request = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
